// File: rtl/m_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage.
//
// One iteration per clock for WIDTH clocks after the accept edge, then a
// one-cycle DONE state with o_done high. MUL/MULHU use shift-add into a
// 2*WIDTH accumulator; DIVU/REMU use restoring division, MSB first, with the
// remainder in the accumulator's upper half and the quotient in its lower half.
//
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset
//   i_start  - request; accepted in IDLE or DONE, ignored while running
//   i_op     - 0=MUL, 1=MULHU, 2=DIVU, 3=REMU
//   i_a/i_b  - operands, latched on the accept edge
//   o_busy   - high while iterating
//   o_done   - one-cycle pulse when o_result is updated
//   o_result - last completed result, held until the next completion
module m_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] OpMul   = 2'd0;
  localparam logic [1:0] OpMulhu = 2'd1;
  localparam logic [1:0] OpDivu  = 2'd2;
  localparam logic [1:0] OpRemu  = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Both divide ops have op[1] set.
  logic is_div;
  assign is_div = op_q[1];

  logic [WIDTH-1:0]   acc_hi, acc_lo, mul_addend, div_diff;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;

  // One iteration of the selected algorithm applied to the current accumulator.
  always_comb begin
    acc_hi     = acc_q[2*WIDTH-1:WIDTH];
    acc_lo     = acc_q[WIDTH-1:0];
    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift the whole product right, keeping the carry.
    mul_addend = opb_q[0] ? opa_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    // Divide: shift the next dividend bit into the partial remainder. A zero
    // divisor always "fits", giving an all-ones quotient and remainder = i_a.
    div_shift  = {acc_hi, opa_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opb_q});
    div_diff   = div_shift[WIDTH-1:0] - opb_q;
    if (is_div) begin
      acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_lo[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (i_start) begin
          state_d = StRun;
          op_d    = i_op;
          opa_d   = i_a;
          opb_d   = i_b;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          opa_d = opa_q << 1;
        end else begin
          opb_d = opb_q >> 1;
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          case (op_q)
            OpMul, OpDivu:   result_d = acc_step[WIDTH-1:0];
            OpMulhu, OpRemu: result_d = acc_step[2*WIDTH-1:WIDTH];
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = (state_q == StRun);
  assign o_done   = (state_q == StDone);
  assign o_result = result_q;

endmodule

// File: tb/tb_m_muldiv_unit.sv
// Self-checking bench for m_muldiv_unit: directed operations with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_m_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  m_muldiv_unit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Arithmetic meaning of each op, including the divide-by-zero rules.
  function automatic logic [W-1:0] ref_fn(input logic [1:0] f_op, input logic [W-1:0] f_a,
                                          input logic [W-1:0] f_b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, f_a} * {{W{1'b0}}, f_b};
    case (f_op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (f_b == 0) ? {W{1'b1}} : f_a / f_b;
      default: return (f_b == 0) ? f_a : f_a % f_b;
    endcase
  endfunction

  // Timeline model: an accepted request completes W edges later.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_done   <= 1'b1;
          m_result <= m_pending;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_left    <= W;
        m_pending <= ref_fn(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_left != 0));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_result", result, m_result);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom_range(3));
  endtask

  // Called right after the accept edge; scrambles inputs while running.
  task automatic wait_done(input string name, input logic [W-1:0] exp, input int pulse_at);
    int lat = 0;
    int busy_cyc;
    bit seen = 1'b0;
    chk({name, "_busy_rise"}, 32'(busy), 32'd1);
    chk({name, "_done_low"}, 32'(done), 32'd0);
    busy_cyc = busy ? 1 : 0;
    while (!seen && lat < 40) begin
      if (lat == pulse_at) start = 1'b1;
      tick();
      lat++;
      start = 1'b0;
      scramble();
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'd32);
    chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'd32);
    chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    chk({name, "_result"}, result, exp);
  endtask

  task automatic do_op(input string name, input logic [1:0] t_op, input logic [W-1:0] t_a,
                       input logic [W-1:0] t_b, input logic [W-1:0] exp, input int pulse_at);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    tick();
    start = 1'b0;
    scramble();
    wait_done(name, exp, pulse_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;

    // Model pins against hand-computed values.
    chk("ref_mul", ref_fn(2'd0, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFE);
    chk("ref_mulhu", ref_fn(2'd1, 32'hFFFF_FFFF, 32'd2), 32'h0000_0001);
    chk("ref_divu", ref_fn(2'd2, 32'd100, 32'd7), 32'd14);
    chk("ref_remu", ref_fn(2'd3, 32'd100, 32'd7), 32'd2);
    chk("ref_div0", ref_fn(2'd2, 32'h1234_5678, 32'd0), 32'hFFFF_FFFF);
    chk("ref_rem0", ref_fn(2'd3, 32'h1234_5678, 32'd0), 32'h1234_5678);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      scramble();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_result", result, 32'd0);
    end

    do_op("mul", 2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, -1);
    tick();
    tick();
    chk("hold_result", result, 32'hFFFF_FFFE);
    do_op("mulhu", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, -1);
    tick();
    do_op("divu", 2'd2, 32'd100, 32'd7, 32'd14, -1);
    tick();
    do_op("remu", 2'd3, 32'd100, 32'd7, 32'd2, -1);
    tick();
    do_op("div0", 2'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, -1);
    tick();
    do_op("rem0", 2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, -1);
    tick();

    // Start pulse on the tenth running edge must be ignored.
    do_op("busy_start", 2'd0, 32'h0000_1234, 32'h0001_0000, 32'h1234_0000, 9);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("busy_start_no_extra_done", 32'(dones), 32'd0);
    chk("busy_start_result_held", result, 32'h1234_0000);

    // Back-to-back: second request issued in the DONE cycle.
    do_op("b2b_first", 2'd2, 32'd100, 32'd3, 32'd33, -1);
    do_op("b2b_second", 2'd2, 32'd9, 32'd3, 32'd3, -1);
    tick();

    // Reset mid-multiply, away from the clock edge.
    start = 1'b1;
    op    = 2'd0;
    a     = 32'h0001_0003;
    b     = 32'h0000_0005;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    chk("midrst_result_after", result, 32'd0);
    do_op("rerun", 2'd0, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, -1);
    tick();

    // A few extra operand patterns against the arithmetic reference.
    for (int i = 0; i < 4; i++) begin
      r_op = 2'(i);
      r_a  = $urandom;
      r_b  = (i >= 2) ? 32'($urandom_range(1000, 1)) : $urandom;
      do_op("rand", r_op, r_a, r_b, ref_fn(r_op, r_a, r_b), -1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m_muldiv_unit.md
Name: m_muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage of the processor datapath.
- Sits directly upstream of the write-back 4:1 result multiplexor; o_result drives one of its data inputs.
- The control unit holds the pipeline while o_busy is high.
- Computes MUL, MULHU, DIVU and REMU on unsigned 32-bit operands with one iteration per clock.

Parameters:
- WIDTH, 32, operand and result width in bits; also the number of iteration cycles.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request pulse; operands and op sampled on the edge where it is accepted
- i_op  input  2  operation: 0=MUL (low word), 1=MULHU (high word), 2=DIVU (quotient), 3=REMU (remainder)
- i_a  input  WIDTH  operand A (multiplicand / dividend)
- i_b  input  WIDTH  operand B (multiplier / divisor)
- o_busy  output  1  high while an operation is iterating
- o_done  output  1  one-cycle pulse: o_result just became valid
- o_result  output  WIDTH  result of the last completed operation, held until the next completion

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE, o_busy=0, o_done=0, o_result=0, internal counter/accumulators=0.
- Reset asserted mid-operation aborts the operation immediately. No o_done is produced.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: result presented for one cycle.
- Accept rule: i_start is accepted on a rising edge when state is IDLE or DONE. i_start in RUN is ignored; nothing is queued.
- Accept edge (E0):
  - Latch i_op, i_a, i_b.
  - Clear the iteration counter and the accumulator.
  - State goes to RUN; o_busy=1 from the next cycle.
- RUN:
  - Exactly one iteration per edge, on E1..E_WIDTH.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring division, one quotient bit per edge, MSB first.
- Completion edge E_WIDTH:
  - o_result loaded per op. MUL = product[WIDTH-1:0]; MULHU = product[2*WIDTH-1:WIDTH]; DIVU = quotient; REMU = remainder.
  - o_busy=0, o_done=1, state goes to DONE.
- Latency: o_done is high in the cycle following edge E_WIDTH, i.e. 32 edges after the accept edge. Latency is fixed and independent of operand values.
- DONE:
  - o_done is high for this cycle only.
  - Next edge returns to IDLE, or to RUN if i_start is high (back-to-back accept, o_done falls, o_busy rises).
- o_result holds its value through IDLE and the following RUN until the next completion edge overwrites it.
- Divide by zero (latched i_b==0): runs the full WIDTH cycles; no exception signal. DIVU result = all ones (0xFFFFFFFF); REMU result = latched i_a.
- Arithmetic is unsigned only. The product register holds the full 2*WIDTH bits, no truncation before selection. Remainder is always < divisor for divisor != 0.
- Input changes on i_a/i_b/i_op after the accept edge have no effect on the running operation.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> o_busy=0, o_done=0, o_result=0; release and idle 5 cycles -> outputs unchanged.
- MUL/MULHU: i_a=0xFFFFFFFF, i_b=0x00000002, op=0 -> o_done exactly 32 cycles after accept, o_result=0xFFFFFFFE. Repeat with op=1 -> o_result=0x00000001.
- DIVU/REMU: i_a=100, i_b=7 -> op=2 gives o_result=14; op=3 gives o_result=2. o_busy high for exactly 32 cycles in each case.
- Divide by zero: i_a=0x12345678, i_b=0 -> op=2 gives 0xFFFFFFFF; op=3 gives 0x12345678. Latency is still 32 cycles.
- Start while busy and back-to-back:
  - Pulse i_start at cycle 10 of a RUN -> ignored, first result unchanged, single o_done.
  - i_start held high in the DONE cycle with i_a=9, i_b=3, op=2 -> new op accepted, next o_done gives 3.
- Reset mid-operation: assert i_rst_n=0 at iteration 15 of a MUL -> o_busy drops asynchronously, no o_done, o_result=0. Re-run after release gives the correct result.
